// File: rtl/fp_vec_issue.sv
// fp_vec_issue
//   Sequencer in front of the 32-lane FP adder tree. Serial FP elements are
//   packed into a lane buffer. One lane-sum computation is started per full
//   (or final partial) chunk. The per-chunk partial sums are chained through
//   the tree's accumulate path, and the vector total is then presented on a
//   valid/ready result port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_vld/in_rdy       element stream handshake
//   in_data, in_last    element value, end-of-vector marker
//   op_sel              tree operation, sampled on the first beat of a vector
//   tree_comp_en        one-cycle start of a lane-sum computation
//   tree_op_sel         latched op_sel
//   tree_lanes          lane buffer, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   tree_accum_comp_en  one-cycle start of an accumulate computation
//   tree_cur_accum_data running accumulator
//   tree_accum_add_data latest chunk partial sum
//   tree_data_out(_vld) tree result, one pulse per started computation
//   res_vld/res_rdy     vector result handshake
//   res_data,res_chunks vector sum and number of chunks
//   err                 sticky tree-response timeout flag
module fp_vec_issue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_last,
    input  logic                          op_sel,
    output logic                          tree_comp_en,
    output logic                          tree_op_sel,
    output logic [LANES*DATA_WIDTH-1:0]   tree_lanes,
    output logic                          tree_accum_comp_en,
    output logic [DATA_WIDTH-1:0]         tree_cur_accum_data,
    output logic [DATA_WIDTH-1:0]         tree_accum_add_data,
    input  logic [DATA_WIDTH-1:0]         tree_data_out,
    input  logic                          tree_data_out_vld,
    output logic                          res_vld,
    input  logic                          res_rdy,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [CNT_W-1:0]              res_chunks,
    output logic                          err
);

    localparam int unsigned IDX_W  = $clog2(LANES);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        FILL,
        ISSUE,
        WAIT_SUM,
        ACC_ISSUE,
        WAIT_ACC,
        OUT
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [LANES*DATA_WIDTH-1:0]   lanes_q, lanes_d;
    logic                          op_q, op_d;
    logic                          last_seen_q, last_seen_d;
    logic [CNT_W-1:0]              chunk_cnt_q, chunk_cnt_d;
    logic [DATA_WIDTH-1:0]         acc_q, acc_d;
    logic [DATA_WIDTH-1:0]         partial_q, partial_d;
    logic [WAIT_W-1:0]             wait_cnt_q, wait_cnt_d;
    logic                          err_q, err_d;
    logic                          in_rdy_q, in_rdy_d;
    logic                          comp_en_q, comp_en_d;
    logic                          acc_en_q, acc_en_d;
    logic                          res_vld_q, res_vld_d;
    logic                          timed_out;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lanes_d     = lanes_q;
        op_d        = op_q;
        last_seen_d = last_seen_q;
        chunk_cnt_d = chunk_cnt_q;
        acc_d       = acc_q;
        partial_d   = partial_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        timed_out   = 1'b0;

        case (state_q)
            FILL: begin
                if (in_vld && in_rdy_q) begin
                    lanes_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    // first beat of a vector: nothing buffered, no chunk done yet
                    if (idx_q == '0 && chunk_cnt_q == '0) begin
                        op_d = op_sel;
                    end
                    if (idx_q == IDX_W'(LANES - 1) || in_last) begin
                        idx_d       = '0;
                        last_seen_d = in_last;
                        state_d     = ISSUE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT_SUM;
            end
            WAIT_SUM: begin
                if (tree_data_out_vld) begin
                    if (chunk_cnt_q != '1) begin
                        chunk_cnt_d = chunk_cnt_q + 1'b1;
                    end
                    if (chunk_cnt_q == '0) begin
                        acc_d   = tree_data_out;
                        state_d = last_seen_q ? OUT : FILL;
                    end else begin
                        partial_d = tree_data_out;
                        state_d   = ACC_ISSUE;
                    end
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ACC_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (tree_data_out_vld) begin
                    acc_d   = tree_data_out;
                    state_d = last_seen_q ? OUT : FILL;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (res_rdy) begin
                    idx_d       = '0;
                    chunk_cnt_d = '0;
                    last_seen_d = 1'b0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        // abandoned vector: drop everything collected so far, keep err sticky
        if (timed_out) begin
            err_d       = 1'b1;
            idx_d       = '0;
            chunk_cnt_d = '0;
            last_seen_d = 1'b0;
            acc_d       = '0;
            partial_d   = '0;
            state_d     = FILL;
        end

        // unwritten lanes of a partial chunk must read as +0.0
        if (state_d == FILL && state_q != FILL) begin
            lanes_d = '0;
        end

        in_rdy_d  = (state_d == FILL);
        comp_en_d = (state_d == ISSUE);
        acc_en_d  = (state_d == ACC_ISSUE);
        res_vld_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            lanes_q     <= '0;
            op_q        <= 1'b0;
            last_seen_q <= 1'b0;
            chunk_cnt_q <= '0;
            acc_q       <= '0;
            partial_q   <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            in_rdy_q    <= 1'b0;
            comp_en_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            res_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lanes_q     <= lanes_d;
            op_q        <= op_d;
            last_seen_q <= last_seen_d;
            chunk_cnt_q <= chunk_cnt_d;
            acc_q       <= acc_d;
            partial_q   <= partial_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            in_rdy_q    <= in_rdy_d;
            comp_en_q   <= comp_en_d;
            acc_en_q    <= acc_en_d;
            res_vld_q   <= res_vld_d;
        end
    end

    assign in_rdy              = in_rdy_q;
    assign tree_comp_en        = comp_en_q;
    assign tree_op_sel         = op_q;
    assign tree_lanes          = lanes_q;
    assign tree_accum_comp_en  = acc_en_q;
    assign tree_cur_accum_data = acc_q;
    assign tree_accum_add_data = partial_q;
    assign res_vld             = res_vld_q;
    assign res_data            = acc_q;
    assign res_chunks          = chunk_cnt_q;
    assign err                 = err_q;

endmodule
